// File: rtl/dsi_tx_pkg.sv
// Shared DSI TX definitions: packet data types and the line scheduler state encoding.
package dsi_tx_pkg;

  localparam logic [5:0] DT_VSS    = 6'h01;
  localparam logic [5:0] DT_HSS    = 6'h21;
  localparam logic [5:0] DT_RGB888 = 6'h3E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSS,
    ST_HSS,
    ST_LHDR,
    ST_PAYLOAD
  } sched_state_t;

endpackage

// File: rtl/dsi_tx_line_scheduler.sv
// DSI video line scheduler: VSS per frame, HSS + long pixel packet per line, payload from show-ahead FIFO.
// Optional macro DSI_TX_SCHED_UNDERFLOW_CNT_EN adds the underflow_cnt output and its saturating counter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | stopped; line_cnt kept so a re-enable can resume mid-frame
// ST_VSS     | VSS short packet header offered, frame_start on acceptance
// ST_HSS     | hdr_valid=0: waiting for a buffered line; else HSS offered
// ST_LHDR    | long pixel packet header offered (word count LINE_BYTES)
// ST_PAYLOAD | streaming LINE_WORDS words straight from the FIFO head
module dsi_tx_line_scheduler
  import dsi_tx_pkg::*;
#(
  parameter int         LINE_BYTES      = 640,
  parameter int         LINES_PER_FRAME = 480,
  parameter logic [5:0] PIX_DATA_TYPE   = DT_RGB888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] fifo_data,
  input  logic        fifo_not_empty,
  input  logic        fifo_line_ready,
  output logic        fifo_read_ack,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [5:0]  hdr_data_type,
  output logic [15:0] hdr_word_count,
  output logic [31:0] pld_data,
  output logic        pld_valid,
  output logic        pld_last,
  input  logic        pld_ready,
  output logic        frame_start,
`ifdef DSI_TX_SCHED_UNDERFLOW_CNT_EN
  output logic [15:0] underflow_cnt,
`endif
  output logic        busy
);

  localparam int LINE_WORDS = LINE_BYTES / 4;
  localparam int WCW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LCW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(LINE_WORDS - 1);
  localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES_PER_FRAME - 1);
  localparam logic [15:0]    LONG_WC   = 16'(LINE_BYTES);

  sched_state_t   state;
  logic [WCW-1:0] word_cnt;
  logic [LCW-1:0] line_cnt;
  logic           in_payload;
  logic           xfer;
  logic           hdr_acc;

  // Payload path is combinational from the FIFO head so words move with zero latency.
  assign in_payload    = (state == ST_PAYLOAD);
  assign pld_valid     = in_payload & fifo_not_empty;
  assign pld_data      = in_payload ? fifo_data : 32'h0;
  assign pld_last      = pld_valid & (word_cnt == LAST_WORD);
  assign xfer          = pld_valid & pld_ready;
  assign fifo_read_ack = xfer;
  assign hdr_acc       = hdr_valid & hdr_ready;
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      word_cnt       <= '0;
      line_cnt       <= '0;
      hdr_valid      <= 1'b0;
      hdr_data_type  <= 6'h0;
      hdr_word_count <= 16'h0;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            if (line_cnt != '0) begin
              state <= ST_HSS;
            end else begin
              state          <= ST_VSS;
              hdr_valid      <= 1'b1;
              hdr_data_type  <= DT_VSS;
              hdr_word_count <= 16'h0;
            end
          end
        end
        ST_VSS: begin
          if (hdr_acc) begin
            // Preload HSS so it follows VSS by one cycle when a line is already buffered.
            frame_start    <= 1'b1;
            state          <= ST_HSS;
            hdr_valid      <= fifo_line_ready;
            hdr_data_type  <= DT_HSS;
            hdr_word_count <= 16'h0;
          end
        end
        ST_HSS: begin
          if (hdr_valid) begin
            if (hdr_ready) begin
              state          <= ST_LHDR;
              hdr_data_type  <= PIX_DATA_TYPE;
              hdr_word_count <= LONG_WC;
            end
          end else if (fifo_line_ready) begin
            hdr_valid      <= 1'b1;
            hdr_data_type  <= DT_HSS;
            hdr_word_count <= 16'h0;
          end else if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_LHDR: begin
          if (hdr_acc) begin
            state     <= ST_PAYLOAD;
            hdr_valid <= 1'b0;
            word_cnt  <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            if (pld_last) begin
              word_cnt <= '0;
              if (line_cnt == LAST_LINE) begin
                line_cnt <= '0;
                if (enable) begin
                  state          <= ST_VSS;
                  hdr_valid      <= 1'b1;
                  hdr_data_type  <= DT_VSS;
                  hdr_word_count <= 16'h0;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                line_cnt <= line_cnt + 1'b1;
                state    <= enable ? ST_HSS : ST_IDLE;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DSI_TX_SCHED_UNDERFLOW_CNT_EN
  // Counts cycles where the assembler could take a word but the FIFO ran dry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= 16'h0;
    end else if (in_payload && pld_ready && !fifo_not_empty && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'h1;
    end
  end
`endif

endmodule
